// File: rtl/cm0_dap_sw_cdc_capt_ctrl.sv
// Receive-side 4-phase handshake controller for the DAP serial-wire CDC.
// Synchronises REQ and waits for it to settle. It then issues a one-cycle
// REGEN to the capture bank, raises ACK and pulses VALID to local logic.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_DRAIN   | after reset; wait for req_s low so an in-flight request is
//            | not captured twice
// ST_IDLE    | waiting for a synchronised request
// ST_SETTLE  | request seen; counting extra settle cycles
// ST_WAITRDY | waiting for the local consumer to accept new data
// ST_CAPT    | REGEN high for exactly this cycle
// ST_ACKHI   | ACK high; VALID on the first cycle; wait for request release
module cm0_dap_sw_cdc_capt_ctrl #(
  parameter bit PRESENT     = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 0
) (
  input  logic REGCLK,
  input  logic REGRESET,
  input  logic REQ,
  input  logic LOCALRDY,
  output logic REGEN,
  output logic ACK,
  output logic VALID,
  output logic BUSY
);

  generate
    if (PRESENT) begin : g_ctrl
      typedef enum logic [2:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_SETTLE,
        ST_WAITRDY,
        ST_CAPT,
        ST_ACKHI
      } state_t;

      localparam logic [1:0] SETTLE_INIT = 2'(SETTLE);

      state_t                 state;
      logic [SYNC_STAGES-1:0] sync;
      logic                   req_s;
      logic [1:0]             cnt;

      // Request synchroniser; resets to 1 so a request held through reset
      // is seen as still present and drained rather than captured.
      always_ff @(posedge REGCLK) begin
        if (REGRESET) sync <= '1;
        else          sync <= {sync[SYNC_STAGES-2:0], REQ};
      end

      assign req_s = sync[SYNC_STAGES-1];

      // Handshake FSM with all outputs registered from the next state.
      always_ff @(posedge REGCLK) begin
        if (REGRESET) begin
          state <= ST_DRAIN;
          cnt   <= 2'd0;
          REGEN <= 1'b0;
          ACK   <= 1'b0;
          VALID <= 1'b0;
          BUSY  <= 1'b0;
        end else begin
          REGEN <= 1'b0;
          VALID <= 1'b0;
          case (state)
            ST_DRAIN: begin
              if (!req_s) state <= ST_IDLE;
            end
            ST_IDLE: begin
              if (req_s) begin
                cnt  <= SETTLE_INIT;
                BUSY <= 1'b1;
                if (SETTLE_INIT == 2'd0) state <= ST_WAITRDY;
                else                     state <= ST_SETTLE;
              end
            end
            ST_SETTLE: begin
              // Counter holds at zero; a count of 0 or 1 both leave SETTLE.
              if (cnt != 2'd0) cnt <= cnt - 2'd1;
              if (cnt <= 2'd1) state <= ST_WAITRDY;
            end
            ST_WAITRDY: begin
              if (LOCALRDY) begin
                state <= ST_CAPT;
                REGEN <= 1'b1;
              end
            end
            ST_CAPT: begin
              state <= ST_ACKHI;
              ACK   <= 1'b1;
              VALID <= 1'b1;
            end
            ST_ACKHI: begin
              if (!req_s) begin
                state <= ST_IDLE;
                ACK   <= 1'b0;
                BUSY  <= 1'b0;
              end
            end
            default: begin
              state <= ST_DRAIN;
              ACK   <= 1'b0;
              BUSY  <= 1'b0;
            end
          endcase
        end
      end

`ifdef ARM_ASSERT_ON
      // Request withdrawn before capture is a foreign-side protocol error.
      req_drop_chk: assert property (@(posedge REGCLK) disable iff (REGRESET)
        !(((state == ST_SETTLE) || (state == ST_WAITRDY)) && !req_s));
      // Load enable and acknowledge are mutually exclusive.
      regen_ack_chk: assert property (@(posedge REGCLK) disable iff (REGRESET)
        !(REGEN && ACK));
`endif
    end else begin : g_absent
      // Block removed: outputs tied low, no state.
      assign REGEN = 1'b0;
      assign ACK   = 1'b0;
      assign VALID = 1'b0;
      assign BUSY  = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_sw_cdc_capt_ctrl.sv
// Bench for cm0_dap_sw_cdc_capt_ctrl: cycle vectors, latency sequences and
// a randomised back-to-back handshake run.
module tb_cm0_dap_sw_cdc_capt_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req_a, rdy_a, req_b, rdy_b;
  logic regen_a, ack_a, valid_a, busy_a;
  logic regen_b, ack_b, valid_b, busy_b;
  logic regen_c, ack_c, valid_c, busy_c;

  int checks = 0;
  int errors = 0;

  int n_regen = 0, n_valid = 0, n_ackr = 0, n_overlap = 0;
  logic ack_q = 1'b0;

  always #5 clk = ~clk;

  cm0_dap_sw_cdc_capt_ctrl #(.PRESENT(1'b1), .SYNC_STAGES(2), .SETTLE(0)) dut_a (
    .REGCLK(clk), .REGRESET(rst), .REQ(req_a), .LOCALRDY(rdy_a),
    .REGEN(regen_a), .ACK(ack_a), .VALID(valid_a), .BUSY(busy_a));

  cm0_dap_sw_cdc_capt_ctrl #(.PRESENT(1'b1), .SYNC_STAGES(3), .SETTLE(3)) dut_b (
    .REGCLK(clk), .REGRESET(rst), .REQ(req_b), .LOCALRDY(rdy_b),
    .REGEN(regen_b), .ACK(ack_b), .VALID(valid_b), .BUSY(busy_b));

  cm0_dap_sw_cdc_capt_ctrl #(.PRESENT(1'b0), .SYNC_STAGES(2), .SETTLE(0)) dut_c (
    .REGCLK(clk), .REGRESET(rst), .REQ(req_a), .LOCALRDY(rdy_a),
    .REGEN(regen_c), .ACK(ack_c), .VALID(valid_c), .BUSY(busy_c));

  // Handshake event monitor for dut_a, sampled away from the active edge.
  always @(negedge clk) begin
    if (regen_a) n_regen <= n_regen + 1;
    if (valid_a) n_valid <= n_valid + 1;
    if (ack_a && !ack_q) n_ackr <= n_ackr + 1;
    if (regen_a && ack_a) n_overlap <= n_overlap + 1;
    ack_q <= ack_a;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edges until REGEN is seen high on the chosen instance (bounded).
  task automatic measure_regen(input bit use_b, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!(use_b ? regen_b : regen_a) && edges < 40);
  endtask

  // Edges until ACK is seen low on the chosen instance (bounded).
  task automatic measure_ack_low(input bit use_b, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while ((use_b ? ack_b : ack_a) && edges < 40);
  endtask

  typedef struct {
    logic       rst;
    logic       req;
    logic       rdy;
    logic [3:0] exp;   // {REGEN, ACK, VALID, BUSY} after the edge
  } vec_t;

  vec_t tbl[38];

  initial begin
    int e;
    int base_regen, base_valid, base_ackr, base_ovl, timeouts, n;

    // Reset, single transfer with a 5-cycle LOCALRDY stall, release,
    // reset with REQ held high, and reset during ACKHI.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'b0001};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 4'b0111};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 4'b0101};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b0101};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'b0101};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[23] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[25] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[26] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[27] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[28] = '{1'b0, 1'b1, 1'b1, 4'b0001};
    tbl[29] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[30] = '{1'b0, 1'b1, 1'b1, 4'b0111};
    tbl[31] = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[32] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[33] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[34] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[35] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[36] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[37] = '{1'b0, 1'b0, 1'b1, 4'b0000};

    rst = 1'b1; req_a = 1'b0; rdy_a = 1'b1; req_b = 1'b0; rdy_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 38; i++) begin
      rst   = tbl[i].rst;
      req_a = tbl[i].req;
      rdy_a = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d outs", i), int'({regen_a, ack_a, valid_a, busy_a}),
          int'(tbl[i].exp));
      chk($sformatf("vec%0d absent", i), int'({regen_c, ack_c, valid_c, busy_c}), 0);
    end

    // Baseline latency S=2, SETTLE=0: REGEN visible after the 4th edge.
    req_a = 1'b1;
    measure_regen(1'b0, e);
    chk("a regen latency", e, 4);
    tick();
    chk("a capt->ackhi", int'({regen_a, ack_a, valid_a}), int'(3'b011));
    tick();
    chk("a valid one pulse", int'({regen_a, ack_a, valid_a}), int'(3'b010));
    req_a = 1'b0;
    measure_ack_low(1'b0, e);
    chk("a release latency", e, 3);
    chk("a busy after release", int'(busy_a), 0);

    // S=3, SETTLE=3: exactly 4 edges later than the baseline.
    req_b = 1'b1;
    measure_regen(1'b1, e);
    chk("b regen latency", e, 8);
    chk("b busy at capt", int'(busy_b), 1);
    tick();
    chk("b capt->ackhi", int'({regen_b, ack_b, valid_b}), int'(3'b011));
    req_b = 1'b0;
    measure_ack_low(1'b1, e);
    chk("b release latency", e, 4);

    // Second transfer on dut_b confirms the settle counter reloads.
    tick();
    req_b = 1'b1;
    measure_regen(1'b1, e);
    chk("b regen latency again", e, 8);
    tick();
    req_b = 1'b0;
    measure_ack_low(1'b1, e);
    chk("b release again", e, 4);

    // 100 back-to-back transfers with random phase, jitter and LOCALRDY.
    base_regen = n_regen; base_valid = n_valid; base_ackr = n_ackr;
    base_ovl = n_overlap; timeouts = 0;
    for (int t = 0; t < 100; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        rdy_a = 1'($urandom_range(0, 1));
      end
      #($urandom_range(0, 3));
      req_a = 1'b1;
      n = 0;
      while (!ack_a && n < 200) begin
        @(negedge clk);
        rdy_a = 1'($urandom_range(0, 1));
        n++;
      end
      if (!ack_a) timeouts++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #($urandom_range(0, 3));
      req_a = 1'b0;
      n = 0;
      while (ack_a && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (ack_a) timeouts++;
    end
    rdy_a = 1'b1;
    repeat (3) @(negedge clk);

    chk("rand timeouts", timeouts, 0);
    chk("rand regen count", n_regen - base_regen, 100);
    chk("rand ack rise count", n_ackr - base_ackr, 100);
    chk("rand valid count", n_valid - base_valid, 100);
    chk("rand regen&ack overlap", n_overlap - base_ovl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
